// File: rtl/c499_key_loader.sv
// Bit-serial key loader for the locked c499 SEC datapath.
// Shifts in a 35-bit key plus even parity and commits it only when the parity holds.
module c499_key_loader #(
  parameter int KEY_W    = 35,
  parameter int CNT_W    = 6,
  parameter bit ONE_TIME = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [30:0]      x_key,
  output logic [KEY_W-32:0] p_key,
  output logic             key_loaded,
  output logic             key_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    DONE,
    ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [KEY_W-1:0]   active_q, active_d;
  logic               par_q, par_d;
  logic               loaded_q, loaded_d;
  logic               err_q, err_d;
  logic               restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      par_q    <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      par_q    <= par_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    par_d    = par_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    restart  = 1'b0;
    unique case (state_q)
      IDLE:  restart = key_start;
      SHIFT: begin
        if (key_start) begin
          restart = 1'b1;
        end else if (key_valid) begin
          if (cnt_q < CNT_W'(KEY_W)) begin
            shadow_d = {key_bit, shadow_q[KEY_W-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
          end else begin
            par_d   = key_bit;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if ((^shadow_q ^ par_q) == 1'b0) begin
          active_d = shadow_q;
          loaded_d = 1'b1;
          err_d    = 1'b0;
          state_d  = DONE;
        end else begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      DONE:  restart = key_start && !ONE_TIME;
      ERR:   restart = key_start;
      default: state_d = IDLE;
    endcase
    // Every (re)start wipes partial progress and any stale error flag
    if (restart) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      shadow_d = '0;
      err_d    = 1'b0;
    end
  end

  assign key_ready  = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT) || (state_q == CHECK);
  assign x_key      = active_q[30:0];
  assign p_key      = active_q[KEY_W-1:31];
  assign key_loaded = loaded_q;
  assign key_err    = err_q;

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader.
// Drives a one-time and a reloadable instance from the same stimulus.
module tb_c499_key_loader;

  localparam logic [34:0] K1  = 35'h5A5A5A5A5;
  localparam logic [30:0] K1X = 31'h25A5A5A5;
  localparam logic [3:0]  K1P = 4'hB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_start, key_bit, key_valid;
  logic        rdy1, ld1, er1, bsy1;
  logic        rdy0, ld0, er0, bsy0;
  logic [30:0] x1, x0;
  logic [3:0]  p1, p0;
  int          cyc = 0;
  int          lat;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  c499_key_loader #(.ONE_TIME(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_start(key_start),
    .key_bit(key_bit), .key_valid(key_valid),
    .key_ready(rdy1), .x_key(x1), .p_key(p1),
    .key_loaded(ld1), .key_err(er1), .busy(bsy1)
  );

  c499_key_loader #(.ONE_TIME(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .key_start(key_start),
    .key_bit(key_bit), .key_valid(key_valid),
    .key_ready(rdy0), .x_key(x0), .p_key(p0),
    .key_loaded(ld0), .key_err(er0), .busy(bsy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key_start = 1'b0;
    key_valid = 1'b0;
    key_bit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_load();
    key_start = 1'b1;
    key_valid = 1'b0;
    @(negedge clk);
    key_start = 1'b0;
  endtask

  task automatic send_bits(input logic [35:0] v, input int n,
                           input bit gap);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit = v[i];
      @(negedge clk);
      if (gap && i != n - 1) begin
        key_valid = 1'b0;
        @(negedge clk);
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic send_key(input logic [34:0] k, input logic par,
                          input bit gap);
    int n;
    lat = cyc;
    send_bits({par, k}, 36, gap);
    chk("check_busy", 64'(bsy1 | bsy0), 64'd1);
    n = 0;
    while ((bsy1 || bsy0) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("load_done", 64'(bsy1 | bsy0), 64'd0);
    lat = cyc - lat;
  endtask

  initial begin
    rst_n = 1'b0;
    key_start = 1'b0;
    key_valid = 1'b0;
    key_bit = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_x", 64'(x1), 64'd0);
    chk("rst_p", 64'(p1), 64'd0);
    chk("rst_loaded", 64'(ld1), 64'd0);
    chk("rst_err", 64'(er1), 64'd0);
    chk("rst_ready", 64'(rdy1), 64'd0);
    chk("rst_busy", 64'(bsy1), 64'd0);

    start_load();
    send_key(K1, 1'b1, 1'b0);
    chk("bad_err", 64'(er1), 64'd1);
    chk("bad_loaded", 64'(ld1), 64'd0);
    chk("bad_x", 64'(x1), 64'd0);
    chk("bad_p", 64'(p1), 64'd0);

    start_load();
    chk("err_clr", 64'(er1), 64'd0);
    chk("shift_ready", 64'(rdy1), 64'd1);
    send_key(K1, 1'b0, 1'b0);
    chk("good_x", 64'(x1), 64'(K1X));
    chk("good_p", 64'(p1), 64'(K1P));
    chk("good_loaded", 64'(ld1), 64'd1);
    chk("good_err", 64'(er1), 64'd0);
    chk("good_lat", 64'(lat), 64'd37);
    chk("good_x0", 64'(x0), 64'(K1X));

    start_load();
    chk("lock_ready1", 64'(rdy1), 64'd0);
    chk("lock_busy1", 64'(bsy1), 64'd0);
    chk("reload_ready0", 64'(rdy0), 64'd1);
    chk("reload_keep0", 64'(x0), 64'(K1X));
    send_key(35'h1, 1'b1, 1'b0);
    chk("lock_x1", 64'(x1), 64'(K1X));
    chk("lock_p1", 64'(p1), 64'(K1P));
    chk("reload_x0", 64'(x0), 64'd1);
    chk("reload_p0", 64'(p0), 64'd0);
    chk("reload_ld0", 64'(ld0), 64'd1);

    do_reset();
    @(negedge clk);
    start_load();
    send_key(K1, 1'b0, 1'b1);
    chk("gap_x", 64'(x1), 64'(K1X));
    chk("gap_p", 64'(p1), 64'(K1P));
    chk("gap_lat", 64'(lat), 64'd72);

    do_reset();
    @(negedge clk);
    start_load();
    send_bits(36'hFFFFFFFFF, 10, 1'b0);
    start_load();
    send_key(35'h1, 1'b1, 1'b0);
    chk("abort_x", 64'(x1), 64'd1);
    chk("abort_p", 64'(p1), 64'd0);
    chk("abort_loaded", 64'(ld1), 64'd1);

    start_load();
    send_bits(36'h0, 10, 1'b0);
    chk("mid_busy", 64'(bsy0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bsy0), 64'd0);
    chk("arst_ready", 64'(rdy0), 64'd0);
    chk("arst_loaded", 64'(ld0), 64'd0);
    chk("arst_x", 64'(x0), 64'd0);
    chk("arst_x1", 64'(x1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/c499_key_loader.md
Name: c499_key_loader

Overview:
- Serial key-load controller upstream of the locked c499 SEC datapath.
- Receives a 35-bit unlock key plus one even-parity bit over a valid/ready bit-serial link.
- Checks the parity, then commits the key to a stable register driving the datapath key inputs X_1..X_31 (XOR key) and p1..p4 (mux key).
- The datapath sees only committed keys; it never sees a partially shifted one.

Parameters:
- KEY_W, 35, key length in bits; [30:0] = XOR key, [34:31] = mux key.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > KEY_W.
- ONE_TIME, 1, when 1, a committed key can be replaced only by reset.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- key_start, input, 1, single-cycle request to begin a load.
- key_bit, input, 1, serial key/parity data, LSB first.
- key_valid, input, 1, key_bit is valid this cycle.
- key_ready, output, 1, loader accepts a bit this cycle.
- x_key, output, 31, committed XOR key; x_key[i] drives X_(i+1).
- p_key, output, 4, committed mux key; p_key[i] drives p(i+1).
- key_loaded, output, 1, a committed key is active.
- key_err, output, 1, the last load failed the parity check.
- busy, output, 1, a load is in progress (SHIFT or CHECK).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state = IDLE; shadow, active key and counter = 0; x_key = 0; p_key = 0; key_ready, key_loaded, key_err and busy = 0.
- States: IDLE, SHIFT, CHECK, DONE, ERR.
- IDLE:
  - key_start -> SHIFT; counter and shadow are cleared.
- SHIFT:
  - key_ready = 1 and busy = 1.
  - A bit is accepted on an edge where key_valid && key_ready.
  - While counter < KEY_W: shadow <= {key_bit, shadow[KEY_W-1:1]} and counter increments. The first bit accepted lands in shadow[0] after all KEY_W shifts.
  - When counter == KEY_W, the accepted bit is the parity bit. It is latched and the state goes to CHECK.
  - key_valid low stalls with no timeout and no state change.
- CHECK (exactly one cycle):
  - key_ready = 0 and busy = 1.
  - If XOR(shadow) ^ parity == 0: active <= shadow, key_loaded <= 1, key_err <= 0, next state DONE.
  - Otherwise: active is unchanged, key_err <= 1, next state ERR. key_loaded keeps its prior value.
- Latency: x_key and p_key change on the edge one cycle after the parity-bit acceptance edge. Total load time is at least KEY_W+2 cycles from the first accepted bit.
- DONE:
  - key_start with ONE_TIME = 0 -> SHIFT. key_loaded stays 1 and the old key stays active until the new commit.
  - key_start with ONE_TIME = 1 is ignored; the block is permanently locked until reset.
- ERR:
  - key_start -> SHIFT; key_err clears on entry to SHIFT.
  - A failed key never reaches the outputs.
- key_start during SHIFT: abort and restart; counter and shadow are cleared in the same edge.
- key_start during CHECK is ignored; CHECK always completes.
- key_start and key_valid in the same IDLE cycle: only the start is taken. The bit is not accepted because key_ready = 0 in IDLE.
- x_key = active[30:0] and p_key = active[34:31], registered and glitch-free.
- Counter saturates logic at KEY_W. No wrap-around is possible because the state leaves SHIFT at the parity bit.
- Reset asserted mid-load: everything returns to reset values immediately and asynchronously, including a previously committed key.

Test Plan:
- Reset, then check outputs -> x_key = 0, p_key = 0, key_loaded = 0, key_err = 0, key_ready = 0, busy = 0.
- Start, shift key 0x5A5A5A5A5 LSB-first with continuous valid, then parity 0 -> one cycle after the parity edge x_key = 0x25A5A5A5, p_key = 0xB, key_loaded = 1, key_err = 0, busy = 0.
- Same key with parity 1 -> key_err = 1, key_loaded = 0, x_key = 0, p_key = 0; then a correct reload succeeds and key_err clears at the start.
- Valid toggled 1-0-1 every cycle during load -> identical committed key; load takes 2x the cycles.
- Start, 10 bits, start again, then full key 0x000000001 with parity 1 -> x_key = 0x1; the aborted bits are not visible.
- ONE_TIME = 1: after commit of 0x5A5A5A5A5, key_start plus a new key -> key_ready stays 0 and the key is unchanged. Repeat with ONE_TIME = 0 -> the new key commits. Assert rst_n mid-shift -> immediate return to reset values.
